// File: rtl/decode_pkg.sv
// Shared defaults and control-bundle field positions for the WISC decode stage.
package decode_pkg;

  localparam int unsigned DEF_DATA_W     = 16;
  localparam int unsigned DEF_REG_ADDR_W = 3;
  localparam int unsigned DEF_NUM_REGS   = 8;
  localparam int unsigned DEF_CTRL_W     = 16;

  // Field layout inside the opaque control bundle handed to EX
  localparam int unsigned CTRL_ALU_OP_LSB    = 0;
  localparam int unsigned CTRL_ALU_OP_W      = 4;
  localparam int unsigned CTRL_BR_SEL_LSB    = 4;
  localparam int unsigned CTRL_BR_SEL_W      = 3;
  localparam int unsigned CTRL_JUMP_BIT      = 7;
  localparam int unsigned CTRL_MEM_WRITE_BIT = 8;

endpackage

// File: rtl/regfile_bypass.sv
// N-entry register file, two combinational read ports with write-to-read bypass.
module regfile_bypass
  import decode_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int unsigned NUM_REGS   = DEF_NUM_REGS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_sel,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [REG_ADDR_W-1:0] rd_sel1,
  input  logic [REG_ADDR_W-1:0] rd_sel2,
  output logic [DATA_W-1:0]     rd_data1,
  output logic [DATA_W-1:0]     rd_data2
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        if (wr_en && wr_sel == REG_ADDR_W'(i)) regs[i] <= wr_data;
    end
  end

  // Selects that match no implemented entry fall through to 0, bypass included
  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rd_sel1 == REG_ADDR_W'(i))
        rd_data1 = (wr_en && wr_sel == rd_sel1) ? wr_data : regs[i];
      if (rd_sel2 == REG_ADDR_W'(i))
        rd_data2 = (wr_en && wr_sel == rd_sel2) ? wr_data : regs[i];
    end
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode-stage datapath: register file, load-use hazard detect and ID/EX register.
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int unsigned NUM_REGS   = DEF_NUM_REGS,
  parameter int unsigned CTRL_W     = DEF_CTRL_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic                  in_rs1_used,
  input  logic                  in_rs2_used,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_write,
  input  logic                  in_mem_read,
  input  logic [CTRL_W-1:0]     in_ctrl,
  input  logic [DATA_W-1:0]     in_imm,
  output logic                  in_ready,
  input  logic                  wb_write,
  input  logic [REG_ADDR_W-1:0] wb_sel,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  ex_stall,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [REG_ADDR_W-1:0] out_rs1,
  output logic [REG_ADDR_W-1:0] out_rs2,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_write,
  output logic                  out_mem_read,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic [DATA_W-1:0]     out_imm,
  output logic [DATA_W-1:0]     out_data1,
  output logic [DATA_W-1:0]     out_data2,
  output logic                  hazard_stall,
  output logic                  err
);

  logic [DATA_W-1:0] rf_data1;
  logic [DATA_W-1:0] rf_data2;
  logic              wb_oor;
  logic              rs1_oor;
  logic              rs2_oor;
  logic              err_event;

  regfile_bypass #(
    .DATA_W    (DATA_W),
    .REG_ADDR_W(REG_ADDR_W),
    .NUM_REGS  (NUM_REGS)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wb_write),
    .wr_sel  (wb_sel),
    .wr_data (wb_data),
    .rd_sel1 (in_rs1),
    .rd_sel2 (in_rs2),
    .rd_data1(rf_data1),
    .rd_data2(rf_data2)
  );

  always_comb begin
    wb_oor    = 32'(wb_sel) >= NUM_REGS;
    rs1_oor   = 32'(in_rs1) >= NUM_REGS;
    rs2_oor   = 32'(in_rs2) >= NUM_REGS;
    err_event = (wb_write & wb_oor) |
                (in_valid & ((in_rs1_used & rs1_oor) | (in_rs2_used & rs2_oor)));
  end

  // out_valid gating keeps a bubble from matching even if stale control lingered
  always_comb begin
    hazard_stall = in_valid & out_valid & out_mem_read & out_reg_write &
                   ((in_rs1_used & (in_rs1 == out_rd)) |
                    (in_rs2_used & (in_rs2 == out_rd)));
    in_ready     = ~ex_stall & ~hazard_stall & ~rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_rs1       <= '0;
      out_rs2       <= '0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      out_mem_read  <= 1'b0;
      out_ctrl      <= '0;
      out_imm       <= '0;
      out_data1     <= '0;
      out_data2     <= '0;
      err           <= 1'b0;
    end else begin
      if (err_event) err <= 1'b1;

      if (flush || (!ex_stall && hazard_stall)) begin
        out_valid     <= 1'b0;
        out_reg_write <= 1'b0;
        out_mem_read  <= 1'b0;
        out_ctrl      <= '0;
      end else if (ex_stall) begin
        // Held operands must track write-back or EX would consume stale data
        if (wb_write && !wb_oor && wb_sel == out_rs1) out_data1 <= wb_data;
        if (wb_write && !wb_oor && wb_sel == out_rs2) out_data2 <= wb_data;
      end else begin
        out_valid     <= in_valid;
        out_rs1       <= in_rs1;
        out_rs2       <= in_rs2;
        out_rd        <= in_rd;
        out_reg_write <= in_valid & in_reg_write;
        out_mem_read  <= in_valid & in_mem_read;
        out_ctrl      <= in_valid ? in_ctrl : '0;
        out_imm       <= in_imm;
        out_data1     <= rf_data1;
        out_data2     <= rf_data2;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe with a behavioural ID/EX model and literal pins.
module tb_decode_stage_pipe;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_rs1_used, in_rs2_used, in_reg_write, in_mem_read;
  logic [2:0]  in_rs1, in_rs2, in_rd, wb_sel;
  logic [15:0] in_ctrl, in_imm, wb_data;
  logic        wb_write, ex_stall, flush;

  logic        in_ready, out_valid, out_reg_write, out_mem_read, hazard_stall, err;
  logic [2:0]  out_rs1, out_rs2, out_rd;
  logic [15:0] out_ctrl, out_imm, out_data1, out_data2;

  logic        d6_in_ready, d6_out_valid, d6_out_reg_write, d6_out_mem_read, d6_hazard_stall, d6_err;
  logic [2:0]  d6_out_rs1, d6_out_rs2, d6_out_rd;
  logic [15:0] d6_out_ctrl, d6_out_imm, d6_out_data1, d6_out_data2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage_pipe #(.DATA_W(16), .REG_ADDR_W(3), .NUM_REGS(8), .CTRL_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_ctrl(in_ctrl),
    .in_imm(in_imm), .in_ready(in_ready), .wb_write(wb_write), .wb_sel(wb_sel),
    .wb_data(wb_data), .ex_stall(ex_stall), .flush(flush), .out_valid(out_valid),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_ctrl(out_ctrl), .out_imm(out_imm),
    .out_data1(out_data1), .out_data2(out_data2), .hazard_stall(hazard_stall), .err(err)
  );

  decode_stage_pipe #(.DATA_W(16), .REG_ADDR_W(3), .NUM_REGS(6), .CTRL_W(16)) dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_ctrl(in_ctrl),
    .in_imm(in_imm), .in_ready(d6_in_ready), .wb_write(wb_write), .wb_sel(wb_sel),
    .wb_data(wb_data), .ex_stall(ex_stall), .flush(flush), .out_valid(d6_out_valid),
    .out_rs1(d6_out_rs1), .out_rs2(d6_out_rs2), .out_rd(d6_out_rd),
    .out_reg_write(d6_out_reg_write), .out_mem_read(d6_out_mem_read), .out_ctrl(d6_out_ctrl),
    .out_imm(d6_out_imm), .out_data1(d6_out_data1), .out_data2(d6_out_data2),
    .hazard_stall(d6_hazard_stall), .err(d6_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural registers plus the ID/EX contents
  typedef struct packed {
    logic        v, rw, mr;
    logic [2:0]  rs1, rs2, rd;
    logic [15:0] ctrl, imm, d1, d2;
  } idex_t;

  idex_t       m;
  logic [15:0] m_regs [8];
  logic        m_err6;
  logic        m_init = 1'b0;

  function automatic logic [15:0] m_read(input logic [2:0] s);
    if (wb_write && wb_sel == s) return wb_data;
    return m_regs[s];
  endfunction

  function automatic logic m_hazard();
    return in_valid && m.v && m.mr && m.rw &&
           ((in_rs1_used && in_rs1 == m.rd) || (in_rs2_used && in_rs2 == m.rd));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m = '0;
      foreach (m_regs[k]) m_regs[k] = 16'h0;
      m_err6 = 1'b0;
      m_init = 1'b1;
    end else if (m_init) begin
      logic hz;
      logic [15:0] r1, r2;
      hz = m_hazard();
      r1 = m_read(in_rs1);
      r2 = m_read(in_rs2);
      if (flush || (!ex_stall && hz)) begin
        m.v = 0; m.rw = 0; m.mr = 0; m.ctrl = 0;
      end else if (ex_stall) begin
        if (wb_write && wb_sel == m.rs1) m.d1 = wb_data;
        if (wb_write && wb_sel == m.rs2) m.d2 = wb_data;
      end else begin
        m.v = in_valid; m.rs1 = in_rs1; m.rs2 = in_rs2; m.rd = in_rd;
        m.rw = in_valid && in_reg_write; m.mr = in_valid && in_mem_read;
        m.ctrl = in_valid ? in_ctrl : 16'h0; m.imm = in_imm; m.d1 = r1; m.d2 = r2;
      end
      if (wb_write) m_regs[wb_sel] = wb_data;
      if ((wb_write && wb_sel >= 6) ||
          (in_valid && ((in_rs1_used && in_rs1 >= 6) || (in_rs2_used && in_rs2 >= 6))))
        m_err6 = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("out_valid", out_valid, m.v);
      chk("out_reg_write", out_reg_write, m.rw);
      chk("out_mem_read", out_mem_read, m.mr);
      chk("out_rs1", out_rs1, m.rs1);
      chk("out_rs2", out_rs2, m.rs2);
      chk("out_rd", out_rd, m.rd);
      chk("out_ctrl", out_ctrl, m.ctrl);
      chk("out_imm", out_imm, m.imm);
      chk("out_data1", out_data1, m.d1);
      chk("out_data2", out_data2, m.d2);
      chk("hazard_stall", hazard_stall, m_hazard());
      chk("in_ready", in_ready, !ex_stall && !m_hazard() && !rst);
      chk("err", err, 1'b0);
      chk("err6", d6_err, m_err6);
    end
  end

  task automatic clr();
    rst = 0; in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rs1_used = 0; in_rs2_used = 0;
    in_rd = 0; in_reg_write = 0; in_mem_read = 0; in_ctrl = 0; in_imm = 0;
    wb_write = 0; wb_sel = 0; wb_data = 0; ex_stall = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_rd(input logic [2:0] rd);
    clr(); in_valid = 1; in_rd = rd; in_reg_write = 1; in_mem_read = 1;
    in_ctrl = 16'h00A5; in_imm = 16'h0010;
    tick();
  endtask

  initial begin
    clr();
    rst = 1;
    tick(); tick();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_ctrl", out_ctrl, 16'h0);
    rst = 0;

    // Fresh register file reads as zero on both ports
    for (int i = 0; i < 8; i++) begin
      clr(); in_valid = 1; in_rs1 = 3'(i); in_rs2 = 3'(7 - i);
      in_rs1_used = 1; in_rs2_used = 1; in_rd = 3'(i); in_imm = 16'(16'h100 + i); in_ctrl = 16'(i);
      tick();
      chk("r0_7_d1", out_data1, 16'h0000);
      chk("r0_7_d2", out_data2, 16'h0000);
    end

    clr(); in_valid = 1; in_rs1 = 3; in_rs1_used = 1;
    wb_write = 1; wb_sel = 3; wb_data = 16'hBEEF;
    tick();
    chk("bypass_d1", out_data1, 16'hBEEF);
    clr(); in_valid = 1; in_rs2 = 3; in_rs2_used = 1;
    tick();
    chk("r3_stored", out_data2, 16'hBEEF);

    // Load-use on rs2: one bubble, then issue
    load_rd(2);
    chk("load_mr", out_mem_read, 1'b1);
    clr(); in_valid = 1; in_rs2 = 2; in_rs2_used = 1; in_rd = 4; in_reg_write = 1; in_ctrl = 16'h0033;
    #1;
    chk("hz_set", hazard_stall, 1'b1);
    chk("hz_ready", in_ready, 1'b0);
    tick();
    chk("hz_bubble", out_valid, 1'b0);
    chk("hz_bubble_rw", out_reg_write, 1'b0);
    chk("hz_cleared", hazard_stall, 1'b0);
    tick();
    chk("hz_issue", out_valid, 1'b1);
    chk("hz_issue_rd", out_rd, 3'd4);
    chk("hz_issue_d2", out_data2, 16'h0000);

    load_rd(2);
    clr(); in_valid = 1; in_rs2 = 2; in_rs2_used = 0; in_rs1 = 5; in_rs1_used = 1;
    #1;
    chk("unused_nostall", hazard_stall, 1'b0);
    tick();
    chk("unused_issue", out_valid, 1'b1);

    load_rd(6);
    clr(); in_valid = 1; in_rs1 = 6; in_rs1_used = 1;
    #1;
    chk("hz_rs1", hazard_stall, 1'b1);
    tick(); tick();

    // EX stall with write-back to a held source
    clr(); in_valid = 1; in_rs1 = 1; in_rs1_used = 1; in_rs2 = 3; in_rs2_used = 1;
    in_rd = 6; in_reg_write = 1; in_imm = 16'h0042; in_ctrl = 16'(1 << CTRL_MEM_WRITE_BIT);
    tick();
    chk("pre_stall_d2", out_data2, 16'hBEEF);
    clr(); ex_stall = 1; in_valid = 1; in_rs1 = 5; in_rs1_used = 1; in_imm = 16'hFFFF;
    wb_write = 1; wb_sel = 1; wb_data = 16'h1234;
    #1;
    chk("stall_ready", in_ready, 1'b0);
    tick();
    wb_write = 0;
    tick(); tick();
    chk("stall_refresh", out_data1, 16'h1234);
    chk("stall_rs1", out_rs1, 3'd1);
    chk("stall_imm", out_imm, 16'h0042);
    chk("stall_ctrl", out_ctrl, 16'h0100);
    ex_stall = 0;
    tick();
    chk("post_stall_imm", out_imm, 16'hFFFF);

    // Flush beats both ex_stall and a pending load-use
    load_rd(5);
    clr(); in_valid = 1; in_rs1 = 5; in_rs1_used = 1; ex_stall = 1; flush = 1;
    #1;
    chk("flush_hz", hazard_stall, 1'b1);
    chk("flush_ready", in_ready, 1'b0);
    tick();
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_rw", out_reg_write, 1'b0);
    chk("flush_ctrl", out_ctrl, 16'h0000);

    // Out-of-range behaviour on the 6-register instance
    clr(); rst = 1; tick(); rst = 0;
    chk("err6_rst", d6_err, 1'b0);
    wb_write = 1; wb_sel = 5; wb_data = 16'h5555;
    tick();
    wb_sel = 7; wb_data = 16'hDEAD;
    tick();
    chk("err6_wb7", d6_err, 1'b1);
    chk("err8_wb7", err, 1'b0);
    clr(); in_valid = 1; in_rs1 = 5; in_rs1_used = 1; in_rs2 = 7; in_rs2_used = 1;
    tick();
    chk("d6_r5", d6_out_data1, 16'h5555);
    chk("d6_r7_zero", d6_out_data2, 16'h0000);
    chk("d8_r7", out_data2, 16'hDEAD);
    clr(); tick(); tick(); tick();
    chk("err6_sticky", d6_err, 1'b1);
    rst = 1; tick(); rst = 0;
    chk("err6_cleared", d6_err, 1'b0);
    in_valid = 1; in_rs2 = 6; in_rs2_used = 1;
    tick();
    chk("err6_read", d6_err, 1'b1);
    clr(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
